ppu_bg_shifter: RTL and testbench

PPU_BG_SHIFTER -- requirements
Module: ppu_bg_shifter

---
 rtl/ppu_pkg.sv | 27 ++
 rtl/ppu_tile_fifo.sv | 52 +++++
 rtl/ppu_bg_shifter.sv | 196 +++++++++++++++++++
 tb/tb_ppu_bg_shifter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: values shared by the background pixel shifter and its tile FIFO.
//   PPU_LINE_PIXELS / PPU_TILE_W : default visible pixels per line and pixels per tile row
//   TILE_ENTRY_W                 : width of one buffered tile row {pal[1:0], hi[7:0], lo[7:0]}
//   bg_state_e                   : shifter control states (IDLE, PRIME, ACTIVE)
//   pal_pack()                   : palette-address packing; colour 0 is the shared backdrop
package ppu_pkg;

  localparam int PPU_LINE_PIXELS = 256;
  localparam int PPU_TILE_W      = 8;
  localparam int TILE_ENTRY_W    = 18;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRIME  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  typedef enum logic [1:0] {
    BG_IDLE   = ST_IDLE,
    BG_PRIME  = ST_PRIME,
    BG_ACTIVE = ST_ACTIVE
  } bg_state_e;

  // Every palette's colour 0 maps to entry 0 (backdrop).
  function automatic logic [4:0] pal_pack(input logic [1:0] pal, input logic [1:0] pix);
    return (pix == 2'b00) ? 5'd0 : {1'b0, pal, pix};
  endfunction

endpackage

// File: rtl/ppu_tile_fifo.sv
// ppu_tile_fifo: 2-entry FIFO of tile rows between the fetch side and the shifter.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   flush      : empties the FIFO at a scanline start; wins over push/pop
//   push/wdata : write one entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   rdata      : head entry, valid whenever empty is low
//   full/empty : occupancy flags
module ppu_tile_fifo
  import ppu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [TILE_ENTRY_W-1:0] wdata,
  output logic [TILE_ENTRY_W-1:0] rdata,
  output logic                    full,
  output logic                    empty
);

  logic [TILE_ENTRY_W-1:0] mem [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;
  logic                    push_ok;
  logic                    pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/ppu_bg_shifter.sv
// ppu_bg_shifter: background pattern shifter for one scanline.
//   clk, rst_n           : clock, synchronous active-low reset
//   line_start, fine_x   : scanline start pulse and fine scroll captured with it
//   pix_en               : request one output pixel this cycle
//   tile_valid/ready     : tile row handshake; tile_lo/hi bitplanes (MSB leftmost), tile_pal
//   pal_addr, palette_en : registered palette index and its valid flag (one cycle after pix_en)
//   line_done            : one-cycle pulse together with the last pixel of the line
//   underrun             : sticky until the next line_start; a tile row was not ready in time
//   dbg_state            : current control state (bg_state_e encoding)
//
// Handshake: a tile row transfers on a rising clk edge where tile_valid and tile_ready are
// both high. tile_ready never depends on tile_valid; the producer holds tile_valid and the
// row data stable until the transfer happens.
module ppu_bg_shifter
  import ppu_pkg::*;
#(
  parameter int LINE_PIXELS = PPU_LINE_PIXELS,
  parameter int TILE_W      = PPU_TILE_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_start,
  input  logic [2:0] fine_x,
  input  logic       pix_en,
  input  logic       tile_valid,
  output logic       tile_ready,
  input  logic [7:0] tile_lo,
  input  logic [7:0] tile_hi,
  input  logic [1:0] tile_pal,
  output logic [4:0] pal_addr,
  output logic       palette_en,
  output logic       line_done,
  output logic       underrun,
  output logic [1:0] dbg_state
);

  // One extra row covers the fine-scroll discard at the left edge.
  localparam int MAX_TILES = LINE_PIXELS / TILE_W + 1;
  localparam int PCNT_W    = $clog2(LINE_PIXELS) + 1;
  localparam int TCNT_W    = $clog2(MAX_TILES) + 1;
  localparam int BCNT_W    = $clog2(TILE_W) + 1;

  localparam logic [PCNT_W-1:0] LAST_PIX = PCNT_W'(LINE_PIXELS - 1);
  localparam logic [TCNT_W-1:0] TILE_CAP = TCNT_W'(MAX_TILES);
  localparam logic [BCNT_W-1:0] ROW_BITS = BCNT_W'(TILE_W);
  localparam logic [BCNT_W-1:0] ONE_BIT  = BCNT_W'(1);

  bg_state_e               state;
  logic [7:0]              sh_lo;
  logic [7:0]              sh_hi;
  logic [1:0]              sh_pal;
  logic                    sh_valid;   // shifter holds a real row; low while starved
  logic [BCNT_W-1:0]       bits_left;
  logic [2:0]              discard;
  logic [PCNT_W-1:0]       pix_cnt;
  logic [TCNT_W-1:0]       tiles_acc;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic [TILE_ENTRY_W-1:0] fifo_rdata;

  logic                    tile_push;
  logic                    pix_go;
  logic [1:0]              cur_pix;
  logic                    last_pix;
  logic                    row_end;
  logic                    prime_load;
  logic                    fill;

  assign dbg_state = state;

  assign tile_ready = rst_n & ~line_start & ~fifo_full &
                      ((state == BG_PRIME) || (state == BG_ACTIVE)) &
                      (tiles_acc < TILE_CAP);
  assign tile_push  = tile_valid & tile_ready;

  assign pix_go     = (state == BG_ACTIVE) & pix_en;
  assign cur_pix    = sh_valid ? {sh_hi[7], sh_lo[7]} : 2'b00;
  assign last_pix   = (pix_cnt == LAST_PIX);
  // Last bit of the row leaves this cycle: reload now so the next pixel has no gap.
  // The final pixel of the line needs no follow-up row.
  assign row_end    = pix_go & sh_valid & (bits_left == ONE_BIT) & ~last_pix;
  assign prime_load = (state == BG_PRIME) & ~sh_valid & ~fifo_empty;
  // Recovery from a starved shifter: take the row as soon as one is buffered.
  assign fill       = (state == BG_ACTIVE) & ~sh_valid & ~fifo_empty & ~(pix_go & last_pix);
  assign fifo_pop   = prime_load | (row_end & ~fifo_empty) | fill;

  ppu_tile_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (line_start),
    .push  (tile_push),
    .pop   (fifo_pop),
    .wdata ({tile_pal, tile_hi, tile_lo}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BG_IDLE;
      sh_lo      <= 8'd0;
      sh_hi      <= 8'd0;
      sh_pal     <= 2'd0;
      sh_valid   <= 1'b0;
      bits_left  <= '0;
      discard    <= 3'd0;
      pix_cnt    <= '0;
      tiles_acc  <= '0;
      pal_addr   <= 5'd0;
      palette_en <= 1'b0;
      line_done  <= 1'b0;
      underrun   <= 1'b0;
    end else if (line_start) begin
      state      <= BG_PRIME;
      sh_lo      <= 8'd0;
      sh_hi      <= 8'd0;
      sh_pal     <= 2'd0;
      sh_valid   <= 1'b0;
      bits_left  <= '0;
      discard    <= fine_x;
      pix_cnt    <= '0;
      tiles_acc  <= '0;
      pal_addr   <= 5'd0;
      palette_en <= 1'b0;
      line_done  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      pal_addr   <= 5'd0;
      palette_en <= 1'b0;
      line_done  <= 1'b0;
      if (tile_push) tiles_acc <= tiles_acc + 1'b1;

      case (state)
        BG_PRIME: begin
          if (prime_load) begin
            sh_lo     <= fifo_rdata[7:0];
            sh_hi     <= fifo_rdata[15:8];
            sh_pal    <= fifo_rdata[17:16];
            sh_valid  <= 1'b1;
            bits_left <= ROW_BITS;
            if (discard == 3'd0) state <= BG_ACTIVE;
          end else if (sh_valid) begin
            // Fine-scroll discard runs one pixel per cycle, independent of pix_en.
            sh_lo     <= {sh_lo[6:0], 1'b0};
            sh_hi     <= {sh_hi[6:0], 1'b0};
            bits_left <= bits_left - ONE_BIT;
            discard   <= discard - 3'd1;
            if (discard == 3'd1) state <= BG_ACTIVE;
          end
        end

        BG_ACTIVE: begin
          if (pix_go) begin
            pal_addr   <= pal_pack(sh_pal, cur_pix);
            palette_en <= 1'b1;
            pix_cnt    <= pix_cnt + 1'b1;
            if (last_pix) begin
              line_done <= 1'b1;
              state     <= BG_IDLE;
            end
          end

          if (fill) begin
            sh_lo     <= fifo_rdata[7:0];
            sh_hi     <= fifo_rdata[15:8];
            sh_pal    <= fifo_rdata[17:16];
            sh_valid  <= 1'b1;
            bits_left <= ROW_BITS;
          end else if (pix_go && sh_valid) begin
            if (row_end) begin
              if (!fifo_empty) begin
                sh_lo     <= fifo_rdata[7:0];
                sh_hi     <= fifo_rdata[15:8];
                sh_pal    <= fifo_rdata[17:16];
                bits_left <= ROW_BITS;
              end else begin
                sh_valid <= 1'b0;
                underrun <= 1'b1;
              end
            end else begin
              sh_lo     <= {sh_lo[6:0], 1'b0};
              sh_hi     <= {sh_hi[6:0], 1'b0};
              bits_left <= bits_left - ONE_BIT;
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_bg_shifter.sv
// tb_ppu_bg_shifter: directed line scenarios with randomized tile data, scroll and pix_en,
// checked against a pixel-stream model built from the tile rows handed to the DUT.
module tb_ppu_bg_shifter;
  import ppu_pkg::*;

  localparam int NPIX  = 256;
  localparam int MAX_T = NPIX / 8 + 1;

  logic       clk;
  logic       rst_n;
  logic       line_start;
  logic [2:0] fine_x;
  logic       pix_en;
  logic       tile_valid;
  logic       tile_ready;
  logic [7:0] tile_lo;
  logic [7:0] tile_hi;
  logic [1:0] tile_pal;
  logic [4:0] pal_addr;
  logic       palette_en;
  logic       line_done;
  logic       underrun;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  logic [17:0] tiles[$];   // rows offered for the current line, in order: {pal, hi, lo}
  int          tile_idx;   // rows transferred so far this line
  logic [4:0]  exp_q[$];
  logic [4:0]  got_q[$];

  ppu_bg_shifter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .fine_x     (fine_x),
    .pix_en     (pix_en),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_lo    (tile_lo),
    .tile_hi    (tile_hi),
    .tile_pal   (tile_pal),
    .pal_addr   (pal_addr),
    .palette_en (palette_en),
    .line_done  (line_done),
    .underrun   (underrun),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pixel p of the line's tile stream (p counts from the left edge of tile 0).
  function automatic logic [4:0] model_px(input int p);
    logic [17:0] t;
    logic [1:0]  px;
    int          b;
    t  = tiles[p / 8];
    b  = 7 - (p % 8);
    px = {t[8 + b], t[b]};
    return (px == 2'b00) ? 5'd0 : {1'b0, t[17:16], px};
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs are set before calling; sample the handshake, cross one rising edge, settle.
  task automatic tick();
    logic hs;
    #1;
    hs = tile_valid & tile_ready;
    @(posedge clk);
    #1;
    if (hs) tile_idx++;
  endtask

  // kind 0: fixed F0/0F pal 2 rows; 1: random rows; 2: random rows with no colour-0 pixel
  task automatic make_tiles(input int kind);
    logic [7:0] lo;
    logic [7:0] hi;
    tiles.delete();
    for (int i = 0; i < MAX_T + 1; i++) begin
      lo = 8'($urandom);
      hi = 8'($urandom);
      if (kind == 2) hi = hi | ~lo;
      if (kind == 0) tiles.push_back({2'd2, 8'h0F, 8'hF0});
      else           tiles.push_back({2'($urandom_range(0, 3)), hi, lo});
    end
  endtask

  // mode 0: pix_en high, 1: toggling, 2: random. Row hold_idx is withheld for hold_len
  // cycles (hold_len=0: no gap). abort_at>0 stops after that many output pixels.
  task automatic run_line(input logic [2:0] fx, input int mode, input int hold_idx,
                          input int hold_len, input int abort_at, input string name);
    int n_out;
    int hold_cnt;
    int cyc;
    bit seen;
    bit done;
    n_out = 0; hold_cnt = 0; cyc = 0; seen = 0; done = 0;
    exp_q.delete();
    got_q.delete();

    line_start = 1'b1;
    fine_x     = fx;
    pix_en     = 1'b1;
    tile_valid = 1'b1;
    {tile_pal, tile_hi, tile_lo} = tiles[0];
    #1;
    check({name, "_ls_ready"}, tile_ready, 0);
    tick();
    line_start = 1'b0;
    tile_idx   = 0;
    check({name, "_ul_clr"}, underrun, 0);

    for (int p = fx; p < fx + NPIX; p++) exp_q.push_back(model_px(p));

    while (!done && cyc < 3000 && !(abort_at > 0 && n_out >= abort_at)) begin
      if (hold_len > 0 && tile_idx == hold_idx && hold_cnt < hold_len) begin
        tile_valid = 1'b0;
        hold_cnt++;
      end else if (tile_idx < tiles.size()) begin
        tile_valid = 1'b1;
        {tile_pal, tile_hi, tile_lo} = tiles[tile_idx];
      end else begin
        tile_valid = 1'b0;
      end
      case (mode)
        0:       pix_en = 1'b1;
        1:       pix_en = ~pix_en;
        default: pix_en = 1'($urandom_range(0, 1));
      endcase
      tick();
      cyc++;

      if (palette_en) begin
        seen = 1;
        n_out++;
        if (hold_len > 0)           got_q.push_back(pal_addr);
        else if (exp_q.size() == 0) check({name, "_extra"}, n_out, NPIX);
        else                        check({name, "_pix"}, pal_addr, exp_q.pop_front());
      end else begin
        check({name, "_idle_addr"}, pal_addr, 0);
      end
      if (seen) check({name, "_en_mirror"}, palette_en, pix_en);
      if (tile_idx >= MAX_T && tile_valid) check({name, "_cap_ready"}, tile_ready, 0);
      if (line_done) begin
        done = 1;
        check({name, "_done_at"}, n_out, NPIX);
      end
    end

    if (abort_at > 0) return;
    if (!done) check({name, "_timeout"}, 0, 1);
    if (hold_len == 0) begin
      check({name, "_left"}, exp_q.size(), 0);
      check({name, "_tiles"}, tile_idx, MAX_T);
    end
    repeat (3) begin
      pix_en     = 1'b1;
      tile_valid = (tile_idx < tiles.size());
      if (tile_valid) {tile_pal, tile_hi, tile_lo} = tiles[tile_idx];
      tick();
      check({name, "_post_en"}, palette_en, 0);
      check({name, "_post_done"}, line_done, 0);
      check({name, "_post_ready"}, tile_ready, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_z;
    int last_z;
    int nz;
    int j;

    rst_n = 1'b0; line_start = 1'b0; fine_x = 3'd0; pix_en = 1'b0;
    tile_valid = 1'b0; tile_lo = 8'd0; tile_hi = 8'd0; tile_pal = 2'd0;
    tile_idx = 0;

    repeat (2) tick();
    check("rst_pal_addr", pal_addr, 0);
    check("rst_palette_en", palette_en, 0);
    check("rst_line_done", line_done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_tile_ready", tile_ready, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick();
    check("idle_state", dbg_state, ST_IDLE);

    make_tiles(0);
    run_line(3'd0, 0, 0, 0, 0, "const");

    make_tiles(1);
    tiles[0] = {2'd1, 8'h00, 8'hFF};
    run_line(3'd3, 0, 0, 0, 0, "fine3");

    for (int r = 0; r < 3; r++) begin
      make_tiles(1);
      run_line(3'($urandom_range(0, 7)), 2, 0, 0, 0, "rand");
      check("rand_ul", underrun, 0);
    end

    make_tiles(1);
    run_line(3'($urandom_range(0, 7)), 1, 0, 0, 0, "toggle");

    // Starve the shifter after two rows; gap pixels are backdrop with palette_en high.
    make_tiles(2);
    run_line(3'd0, 0, 2, 30, 0, "gap");
    first_z = -1; last_z = -1; nz = 0; j = 0;
    foreach (got_q[i]) begin
      if (got_q[i] == 5'd0) begin
        if (first_z < 0) first_z = i;
        last_z = i;
        nz++;
      end else begin
        check("gap_pix", got_q[i], model_px(j));
        j++;
      end
    end
    check("gap_start", first_z, 16);
    check("gap_contig", last_z - first_z + 1, nz);
    check("gap_seen", nz > 0, 1);
    check("gap_underrun", underrun, 1);

    // New line mid-stream: flushed FIFO, counters restart (underrun cleared at line_start).
    make_tiles(1);
    run_line(3'd0, 0, 0, 0, 100, "abort");
    make_tiles(1);
    run_line(3'($urandom_range(0, 7)), 2, 0, 0, 0, "restart");

    make_tiles(2);
    run_line(3'd0, 0, 2, 30, 150, "gap2");
    check("gap2_underrun", underrun, 1);

    // Reset for one cycle mid-line.
    rst_n = 1'b0; pix_en = 1'b1; tile_valid = 1'b1;
    tick();
    rst_n = 1'b0 | 1'b1;
    #1;
    check("mid_rst_pal_addr", pal_addr, 0);
    check("mid_rst_palette_en", palette_en, 0);
    check("mid_rst_line_done", line_done, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_tile_ready", tile_ready, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    repeat (4) begin
      tick();
      check("rst_hold_en", palette_en, 0);
      check("rst_hold_ready", tile_ready, 0);
    end

    // Reset wins over a simultaneous line_start.
    rst_n = 1'b0; line_start = 1'b1;
    tick();
    rst_n = 1'b1; line_start = 1'b0;
    repeat (3) begin
      tick();
      check("rst_vs_ls_state", dbg_state, ST_IDLE);
      check("rst_vs_ls_ready", tile_ready, 0);
      check("rst_vs_ls_en", palette_en, 0);
    end

    make_tiles(1);
    run_line(3'd5, 2, 0, 0, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
